// File: rtl/sm_add_arbiter.sv
// Round-robin arbiter sharing one 8-bit sign-magnitude saturating adder among NUM_REQ clients.
// One operation in flight; the registered result is tagged with the requester index.
module sm_add_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*8-1:0] req_a,
  input  logic [NUM_REQ-1:0]   req_sign_a,
  input  logic [NUM_REQ*8-1:0] req_b,
  input  logic [NUM_REQ-1:0]   req_sign_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 rsp_sign,
  output logic [8:0]           rsp_result,
  output logic                 rsp_sat,
  output logic                 busy,
  output logic [15:0]          op_count,
  output logic [15:0]          sat_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [ID_W-1:0] rr_ptr;
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] ptr_next;

  logic [7:0] op_a;
  logic       op_sa;
  logic [7:0] op_b;
  logic       op_sb;

  logic [8:0] add_sa;
  logic [8:0] add_sb;
  logic [8:0] add_sum;
  logic       add_ovf;
  logic [8:0] add_res;
  logic       add_sign;
  logic       add_sat;

  function automatic logic [ID_W-1:0] wrap_idx(input int v);
    return ID_W'(v % NUM_REQ);
  endfunction

  // Search starts at rr_ptr so the most recently served requester goes last.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && req_valid[wrap_idx(int'(rr_ptr) + k)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_idx(int'(rr_ptr) + k);
      end
    end
  end

  assign ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_found) state_next = CALC;
      CALC:    state_next = HOLD;
      HOLD:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    busy      = (state != IDLE);
    if (rst_n && state == IDLE && grant_found) begin
      req_ready = NUM_REQ'(1) << grant_idx;
    end
  end

  // A negative zero operand maps to 0 here, so it naturally behaves as +0.
  always_comb begin
    add_sa  = op_sa ? -{1'b0, op_a} : {1'b0, op_a};
    add_sb  = op_sb ? -{1'b0, op_b} : {1'b0, op_b};
    add_sum = add_sa + add_sb;
    add_ovf = (add_sa[8] == add_sb[8]) && (add_sum[8] != add_sa[8]);
    add_res  = add_sum;
    add_sign = 1'b0;
    add_sat  = 1'b0;
    if (add_ovf) begin
      add_sat = 1'b1;
      if (add_sum[8]) begin
        add_res  = 9'h0FF;
        add_sign = 1'b0;
      end else begin
        add_res  = 9'h100;
        add_sign = 1'b1;
      end
    end else if (add_sum[8]) begin
      add_res  = -add_sum;
      add_sign = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      op_a       <= '0;
      op_sa      <= 1'b0;
      op_b       <= '0;
      op_sb      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_sign   <= 1'b0;
      rsp_result <= '0;
      rsp_sat    <= 1'b0;
      op_count   <= '0;
      sat_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            op_a   <= req_a[8*grant_idx +: 8];
            op_sa  <= req_sign_a[grant_idx];
            op_b   <= req_b[8*grant_idx +: 8];
            op_sb  <= req_sign_b[grant_idx];
            rsp_id <= grant_idx;
            rr_ptr <= ptr_next;
          end
        end
        CALC: begin
          rsp_sign   <= add_sign;
          rsp_result <= add_res;
          rsp_sat    <= add_sat;
          rsp_valid  <= 1'b1;
          op_count   <= op_count + 16'd1;
          if (add_sat && sat_count != 16'hFFFF) begin
            sat_count <= sat_count + 16'd1;
          end
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_add_arbiter.sv
// Directed bench for sm_add_arbiter: reset, arithmetic corners, round-robin order and backpressure.
module tb_sm_add_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*8-1:0] req_a;
  logic [NUM_REQ-1:0]   req_sign_a;
  logic [NUM_REQ*8-1:0] req_b;
  logic [NUM_REQ-1:0]   req_sign_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic                 rsp_sign;
  logic [8:0]           rsp_result;
  logic                 rsp_sat;
  logic                 busy;
  logic [15:0]          op_count;
  logic [15:0]          sat_count;

  int assert_count = 0;
  int fail_count   = 0;

  sm_add_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_sign_a (req_sign_a),
    .req_b      (req_b),
    .req_sign_b (req_sign_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sign   (rsp_sign),
    .rsp_result (rsp_result),
    .rsp_sat    (rsp_sat),
    .busy       (busy),
    .op_count   (op_count),
    .sat_count  (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input int id, input int a, input bit sa, input int b, input bit sb);
    req_a[8*id +: 8]  = 8'(a);
    req_sign_a[id]    = sa;
    req_b[8*id +: 8]  = 8'(b);
    req_sign_b[id]    = sb;
    req_valid[id]     = 1'b1;
  endtask

  // One full transaction from grant to return-to-IDLE, with rsp_ready held high.
  task automatic run_op(input string tag, input int id, input int a, input bit sa, input int b, input bit sb,
                        input int exp_res, input bit exp_sign, input bit exp_sat);
    apply_stimulus(id, a, sa, b, sb);
    #1;
    check_output({tag, " grant"}, 32'(req_ready), 32'(1 << id));
    @(negedge clk);
    req_valid = '0;
    #1;
    check_output({tag, " calc ready"}, 32'(req_ready), 32'd0);
    check_output({tag, " calc busy"}, 32'(busy), 32'd1);
    check_output({tag, " calc valid"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check_output({tag, " valid"}, 32'(rsp_valid), 32'd1);
    check_output({tag, " id"}, 32'(rsp_id), 32'(id));
    check_output({tag, " result"}, 32'(rsp_result), 32'(exp_res));
    check_output({tag, " sign"}, 32'(rsp_sign), 32'(exp_sign));
    check_output({tag, " sat"}, 32'(rsp_sat), 32'(exp_sat));
    @(negedge clk);
    check_output({tag, " idle valid"}, 32'(rsp_valid), 32'd0);
    check_output({tag, " idle busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '1;
    req_a      = '0;
    req_sign_a = '0;
    req_b      = '0;
    req_sign_b = '0;
    rsp_ready  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_output("reset ready", 32'(req_ready), 32'd0);
    check_output("reset valid", 32'(rsp_valid), 32'd0);
    check_output("reset busy", 32'(busy), 32'd0);
    check_output("reset opcnt", 32'(op_count), 32'd0);
    check_output("reset satcnt", 32'(sat_count), 32'd0);
    req_valid = '0;
    rst_n     = 1'b1;

    $display("[TB] basic and saturation");
    run_op("basic", 0, 100, 0, 27, 1, 73, 0, 0);
    check_output("basic opcnt", 32'(op_count), 32'd1);
    run_op("posovf", 0, 200, 0, 100, 0, 9'h0FF, 0, 1);
    run_op("negovf", 0, 200, 1, 100, 1, 9'h100, 1, 1);
    run_op("neg256", 0, 128, 1, 128, 1, 9'h100, 1, 0);
    check_output("sat satcnt", 32'(sat_count), 32'd2);
    check_output("sat opcnt", 32'(op_count), 32'd4);

    $display("[TB] negative zero");
    run_op("negzero", 3, 0, 1, 0, 1, 0, 0, 0);
    run_op("cancel", 3, 5, 1, 5, 0, 0, 0, 0);
    check_output("nz opcnt", 32'(op_count), 32'd6);

    $display("[TB] backpressure");
    req_valid = '0;
    apply_stimulus(2, 10, 0, 20, 0);
    rsp_ready = 1'b0;
    #1;
    check_output("bp grant", 32'(req_ready), 32'b0100);
    @(negedge clk);
    req_valid = '0;
    apply_stimulus(1, 1, 0, 1, 0);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      check_output("bp valid", 32'(rsp_valid), 32'd1);
      check_output("bp result", 32'(rsp_result), 32'd30);
      check_output("bp id", 32'(rsp_id), 32'd2);
      check_output("bp ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    check_output("bp still held", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    check_output("bp release valid", 32'(rsp_valid), 32'd0);
    check_output("bp release busy", 32'(busy), 32'd0);
    check_output("bp next grant", 32'(req_ready), 32'b0010);

    $display("[TB] reset during HOLD");
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    check_output("hold before reset", 32'(rsp_valid), 32'd1);
    check_output("hold result", 32'(rsp_result), 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("rst valid", 32'(rsp_valid), 32'd0);
    check_output("rst busy", 32'(busy), 32'd0);
    check_output("rst opcnt", 32'(op_count), 32'd0);
    check_output("rst satcnt", 32'(sat_count), 32'd0);
    check_output("rst result", 32'(rsp_result), 32'd0);

    $display("[TB] round-robin");
    rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) apply_stimulus(i, 16 * (i + 1), 0, 1, 0);
    for (int k = 0; k < 6; k++) begin
      #1;
      check_output("rr grant", 32'(req_ready), 32'(1 << (k % NUM_REQ)));
      @(negedge clk);
      check_output("rr calc ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      check_output("rr hold ready", 32'(req_ready), 32'd0);
      check_output("rr id", 32'(rsp_id), 32'(k % NUM_REQ));
      check_output("rr result", 32'(rsp_result), 32'(16 * ((k % NUM_REQ) + 1) + 1));
      @(negedge clk);
    end
    check_output("rr opcnt", 32'(op_count), 32'd6);
    req_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/sm_add_arbiter.md
Name: sm_add_arbiter

Overview:
- Shares one 8-bit sign-magnitude saturating adder among NUM_REQ requesters.
- Each requester sees a valid/ready handshake.
- Arbitration is round-robin, with one operation in flight at a time.
- The registered result is tagged with the requester ID, and a single response channel carries backpressure.
- Sits between client blocks issuing signed additions and the downstream consumer of results.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
ID_W, $clog2(NUM_REQ), width of requester ID (derived, not overridden)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
req_valid  input  NUM_REQ  per-requester operation valid
req_ready  output  NUM_REQ  per-requester accept (one-hot or zero)
req_a  input  NUM_REQ*8  magnitude a, requester i at [8i+7:8i]
req_sign_a  input  NUM_REQ  sign of a (1 = negative)
req_b  input  NUM_REQ*8  magnitude b, packed as req_a
req_sign_b  input  NUM_REQ  sign of b
rsp_valid  output  1  result valid
rsp_ready  input  1  consumer accepts result
rsp_id  output  ID_W  index of requester served
rsp_sign  output  1  result sign
rsp_result  output  9  result magnitude
rsp_sat  output  1  result was saturated
busy  output  1  FSM not in IDLE
op_count  output  16  completed responses, wraps at 0xFFFF->0
sat_count  output  16  saturated responses, sticks at 0xFFFF

Behaviour:
- Reset (rst_n low at a clock edge): state=IDLE, rr_ptr=0, rsp_valid/rsp_id/rsp_sign/rsp_result/rsp_sat=0, op_count=sat_count=0.
  - req_ready is 0 while rst_n is low.
  - Reset wins over every other event, including mid-CALC and mid-HOLD; any in-flight op is dropped.
- FSM states: IDLE, CALC, HOLD.
- IDLE:
  - Grant g = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[g]=1 combinationally in this cycle only; all other bits are 0.
  - On the edge: capture operands of g and g into rsp_id; rr_ptr<=(g+1) mod NUM_REQ; go to CALC.
  - No valid: stay in IDLE, rr_ptr unchanged.
- CALC:
  - Shared adder evaluates the captured operands.
  - Register rsp_sign, rsp_result, rsp_sat; rsp_valid<=1; go to HOLD.
  - Bump op_count; bump sat_count if saturated.
- HOLD:
  - rsp_* held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready=1: rsp_valid<=0 and go to IDLE. No new grant in that cycle.
- req_ready is 0 in CALC and HOLD.
- Latency: accept at cycle T, rsp_valid=1 from T+2. Minimum spacing between grants is 3 cycles.
- Requester dropping req_valid before grant: legal, ignored. Operands are sampled only in the grant cycle.
- busy=1 in CALC and HOLD.
- Adder arithmetic, 9-bit two's complement:
  - sa = sign_a ? -{0,a} : {0,a}; sb likewise; sum = sa+sb (9 bits).
  - Overflow = operands share sign bit and sum sign bit differs.
  - Overflow with sum[8]=1 (positive overflow): result=9'h0FF, sign=0, sat=1.
  - Overflow with sum[8]=0 (negative overflow): result=9'h100, sign=1, sat=1.
  - No overflow, sum<0: result=-sum (9 bits), sign=1, sat=0. sum=-256 gives 9'h100, sign=1, sat=0.
  - No overflow, sum>=0: result=sum, sign=0, sat=0.
  - Negative zero in (sign=1, magnitude=0) is treated as +0. Output is never sign=1 with result=0.

Test Plan:
1. Reset: drive rst_n=0 for 2 cycles while in HOLD -> next cycle rsp_valid=0, busy=0, counters=0. Next grant is requester 0 when all are valid.
2. Basic: req0 a=100 +, b=27 − accepted at T -> at T+2 rsp_valid=1, id=0, result=73, sign=0, sat=0. op_count=1.
3. Saturation:
   - 200+100 -> 0x0FF, sign 0, sat 1.
   - −200+−100 -> 0x100, sign 1, sat 1.
   - −128+−128 -> 0x100, sign 1, sat 0.
   - sat_count=2 afterwards.
4. Round-robin: all four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0,1. Each req_ready is a single-cycle pulse; rsp_id follows the same order.
5. Backpressure: rsp_ready=0 for 5 cycles in HOLD -> rsp_* stable, req_ready=0 throughout. Release -> IDLE next cycle, new grant the cycle after.
6. Negative zero: a=0 −, b=0 − -> result=0, sign=0, sat=0. Also a=5 −, b=5 + -> result=0, sign=0.
